oneshot_blink_ctrl: RTL

ONESHOT_BLINK_CTRL -- requirements
Module: oneshot_blink_ctrl

---
 rtl/oneshot_blink_ctrl_if.sv | 32 +++
 rtl/oneshot_blink_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/oneshot_blink_ctrl_if.sv
// ============================================================================
// Module      : oneshot_blink_ctrl_if
// Description : Trigger and status bundle of the one-shot LED blink controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface oneshot_blink_ctrl_if;
  logic       iBtnPulse;
  logic       oLed;
  logic       oBusy;
  logic       oDone;
  logic [3:0] oBlinkCnt;

  modport master (
    output iBtnPulse,
    input  oLed,
    input  oBusy,
    input  oDone,
    input  oBlinkCnt
  );

  modport slave (
    input  iBtnPulse,
    output oLed,
    output oBusy,
    output oDone,
    output oBlinkCnt
  );
endinterface

`default_nettype wire

// File: rtl/oneshot_blink_ctrl.sv
// ============================================================================
// Module      : oneshot_blink_ctrl
// Description : Button-triggered burst of BLINKS LED on/off blinks.
//               Optional macro ONESHOT_RETRIGGER_EN: a trigger during a burst
//               restarts it; otherwise such triggers are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oneshot_blink_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter int ON_MS    = 250,
  parameter int OFF_MS   = 250,
  parameter int BLINKS   = 3
) (
  input  wire                    CLK,
  input  wire                    RESETn,
  oneshot_blink_ctrl_if.slave    bus
);

  localparam logic [63:0] c_ON_CYC  = 64'(ON_MS) * 64'(TICK_DIV);
  localparam logic [63:0] c_OFF_CYC = 64'(OFF_MS) * 64'(TICK_DIV);
  localparam logic [63:0] c_MAX_CYC = (c_ON_CYC > c_OFF_CYC) ? c_ON_CYC : c_OFF_CYC;
  localparam int          c_CNT_W   = ($clog2(c_MAX_CYC) < 1) ? 1 : $clog2(c_MAX_CYC);

  localparam logic [c_CNT_W-1:0] c_ON_LAST  = c_CNT_W'(c_ON_CYC - 64'd1);
  localparam logic [c_CNT_W-1:0] c_OFF_LAST = c_CNT_W'(c_OFF_CYC - 64'd1);
  localparam logic [3:0]         c_BLINKS   = 4'(BLINKS);

  generate
    if ((BLINKS < 1) || (BLINKS > 15)) begin : g_badBlinks
      $error("oneshot_blink_ctrl: BLINKS must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cycCnt;
  logic [3:0]           r_blinkCnt;
  logic                 r_led;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_start;
  logic [3:0]           w_nextBlink;

  // A trigger always wins over the running sequence when it is allowed to start a burst.
  always_comb begin
    w_start = 1'b0;
`ifdef ONESHOT_RETRIGGER_EN
    w_start = bus.iBtnPulse;
`else
    w_start = bus.iBtnPulse && (r_state == IDLE);
`endif
  end

  assign w_nextBlink = r_blinkCnt + 4'd1;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state    <= IDLE;
      r_cycCnt   <= '0;
      r_blinkCnt <= 4'd0;
      r_led      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_state    <= ON;
        r_cycCnt   <= '0;
        r_blinkCnt <= 4'd0;
        r_led      <= 1'b1;
        r_busy     <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_cycCnt <= '0;
          end
          ON: begin
            if (r_cycCnt == c_ON_LAST) begin
              r_state  <= OFF;
              r_cycCnt <= '0;
              r_led    <= 1'b0;
            end else begin
              r_cycCnt <= r_cycCnt + 1'b1;
            end
          end
          OFF: begin
            if (r_cycCnt == c_OFF_LAST) begin
              r_cycCnt   <= '0;
              r_blinkCnt <= w_nextBlink;
              if (w_nextBlink == c_BLINKS) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= ON;
                r_led   <= 1'b1;
              end
            end else begin
              r_cycCnt <= r_cycCnt + 1'b1;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_cycCnt <= '0;
            r_led    <= 1'b0;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.oLed      = r_led;
  assign bus.oBusy     = r_busy;
  assign bus.oDone     = r_done;
  assign bus.oBlinkCnt = r_blinkCnt;

endmodule

`default_nettype wire
